c3lib_ckg_idle_ctrl: RTL and testbench

Idle-detect clock-enable controller that produces the `clk_en` input of a downstream positive-edge clock gater. It watches a block-activity indication, removes the clock after a programmable number of idle cycles and restores it on activity or an explicit wake request. It answers wake requests with a req/ack handshake once the gated clock is guaranteed running, and keeps a saturating count of gating events for power statistics. It runs entirely on the free-running (ungated) clock.

---
 rtl/c3lib_ckg_pkg.sv | 14 +
 rtl/c3lib_sat_cnt.sv | 31 +++
 rtl/c3lib_ckg_idle_ctrl.sv | 123 ++++++++++++
 tb/tb_c3lib_ckg_idle_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/c3lib_ckg_pkg.sv
// Shared types and default parameters for the idle-detect clock-enable controller.
package c3lib_ckg_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } ckg_state_e;

    localparam int CKG_WAKE_LAT_DFLT = 2;
    localparam int CKG_IDLE_W_DFLT   = 8;

endpackage

// File: rtl/c3lib_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module c3lib_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_d, cnt_q;

    // Next count: clear wins, otherwise step unless already all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/c3lib_ckg_idle_ctrl.sv
// Idle-detect clock-enable controller: gates the downstream clock after a
// programmable idle run, restores it on activity/wake, and acks wake requests
// once the gated clock is known to be running. Runs on the free-running clock.
module c3lib_ckg_idle_ctrl
    import c3lib_ckg_pkg::*;
#(
    parameter int WAKE_LAT = CKG_WAKE_LAT_DFLT,
    parameter int IDLE_W   = CKG_IDLE_W_DFLT,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              busy,
    input  logic              wake_req,
    output logic              wake_ack,
    input  logic [IDLE_W-1:0] cfg_idle_thresh,
    input  logic              cfg_gate_dis,
    input  logic              cnt_clr,
    output logic              clk_en,
    output logic              gated,
    output logic [CNT_W-1:0]  gate_cnt
);

    localparam int WCNT_W = (WAKE_LAT < 2) ? 1 : $clog2(WAKE_LAT);

    ckg_state_e        state_d, state_q;
    logic [IDLE_W-1:0] idle_cnt_d, idle_cnt_q;
    logic [WCNT_W-1:0] wake_cnt_d, wake_cnt_q;
    logic              clk_en_d, clk_en_q;
    logic              gated_d, gated_q;
    logic              wake_ack_d, wake_ack_q;
    logic              ack_done_d, ack_done_q;
    logic              gate_inc;
    logic              wake_any;
    logic [IDLE_W:0]   thresh_n;
    logic [IDLE_W:0]   run_len;

    // Anything that needs the clock on (or blocks gating).
    assign wake_any = busy | wake_req | cfg_gate_dis;

    // Effective threshold (0 behaves as 1) and idle run length including this sample.
    assign thresh_n = (cfg_idle_thresh == '0) ? (IDLE_W+1)'(1) : {1'b0, cfg_idle_thresh};
    assign run_len  = (state_q == RUN) ? (IDLE_W+1)'(1) : ({1'b0, idle_cnt_q} + (IDLE_W+1)'(1));

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        wake_ack_d = 1'b0;
        gate_inc   = 1'b0;
        case (state_q)
            RUN, IDLE_WAIT: begin
                if (wake_any) begin
                    state_d    = RUN;
                    idle_cnt_d = '0;
                    wake_ack_d = wake_req & ~ack_done_q;
                end else if (run_len >= thresh_n) begin
                    // Threshold of 1 gates straight out of RUN on the first idle sample.
                    state_d    = GATED;
                    idle_cnt_d = '0;
                    gate_inc   = 1'b1;
                end else begin
                    state_d    = IDLE_WAIT;
                    idle_cnt_d = (state_q == RUN) ? IDLE_W'(1) : idle_cnt_q + IDLE_W'(1);
                end
            end
            GATED: begin
                if (wake_any) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                end
            end
            WAKE: begin
                wake_cnt_d = wake_cnt_q + WCNT_W'(1);
                if (wake_cnt_q == WCNT_W'(WAKE_LAT - 1)) begin
                    state_d    = RUN;
                    wake_cnt_d = '0;
                    wake_ack_d = wake_req & ~ack_done_q;
                end
            end
            default: state_d = RUN;
        endcase
        // One ack per request: remembered until the request is seen low.
        ack_done_d = wake_req & (ack_done_q | wake_ack_d);
        clk_en_d   = (state_d != GATED);
        gated_d    = (state_d == GATED);
    end

    // State and output registers; reset forces the clock on asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            clk_en_q   <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
            ack_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= clk_en_d;
            gated_q    <= gated_d;
            wake_ack_q <= wake_ack_d;
            ack_done_q <= ack_done_d;
        end
    end

    c3lib_sat_cnt #(.W(CNT_W)) u_gate_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (gate_inc),
        .q     (gate_cnt)
    );

    assign clk_en   = clk_en_q;
    assign gated    = gated_q;
    assign wake_ack = wake_ack_q;

endmodule

// File: tb/tb_c3lib_ckg_idle_ctrl.sv
// Randomized + directed bench for c3lib_ckg_idle_ctrl with a queue scoreboard.
module tb_c3lib_ckg_idle_ctrl;

    localparam int WAKE_LAT = 2;
    localparam int IDLE_W   = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              busy, wake_req, cfg_gate_dis, cnt_clr;
    logic [IDLE_W-1:0] thr;
    logic              wake_ack, clk_en, gated;
    logic [CNT_W-1:0]  gate_cnt;

    always #5 clk = ~clk;

    c3lib_ckg_idle_ctrl #(.WAKE_LAT(WAKE_LAT), .IDLE_W(IDLE_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .busy            (busy),
        .wake_req        (wake_req),
        .wake_ack        (wake_ack),
        .cfg_idle_thresh (thr),
        .cfg_gate_dis    (cfg_gate_dis),
        .cnt_clr         (cnt_clr),
        .clk_en          (clk_en),
        .gated           (gated),
        .gate_cnt        (gate_cnt)
    );

    typedef struct {
        logic             clk_en;
        logic             gated;
        logic             wake_ack;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errs   = 0;

    // Reference model: is the clock on, how long until a wake completes,
    // length of the current idle run, whether the live request was acked,
    // and the saturating gate-event tally.
    bit m_on;
    int m_wake_left;
    int m_idle_run;
    bit m_ack_done;
    int m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 1; m_wake_left = 0; m_idle_run = 0; m_ack_done = 0; m_cnt = 0;
    endtask

    // One clock edge of the model using the inputs the DUT samples.
    task automatic model_step();
        int n;
        bit ack, gate, need;
        n    = (thr == 0) ? 1 : int'(thr);
        ack  = 0;
        gate = 0;
        need = busy || wake_req || cfg_gate_dis;
        if (!m_on) begin
            if (need) begin m_on = 1; m_wake_left = WAKE_LAT; end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
            if (m_wake_left == 0 && wake_req && !m_ack_done) ack = 1;
        end else if (need) begin
            m_idle_run = 0;
            if (wake_req && !m_ack_done) ack = 1;
        end else begin
            m_idle_run++;
            if (m_idle_run >= n) begin m_on = 0; m_idle_run = 0; gate = 1; end
        end
        m_ack_done = wake_req && (m_ack_done || ack);
        if (cnt_clr) m_cnt = 0;
        else if (gate && m_cnt < CNT_MAX) m_cnt++;
        q.push_back('{m_on, !m_on, ack, CNT_W'(m_cnt)});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must react without a clock edge.
    task automatic do_reset(input string where);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk({"rst_clk_en_", where}, 32'(clk_en), 32'd1);
        chk({"rst_wake_ack_", where}, 32'(wake_ack), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({"rst_gated_", where}, 32'(gated), 32'd0);
        chk({"rst_cnt_", where}, 32'(gate_cnt), 32'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents registered outputs; compare to queue head.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("clk_en",   32'(clk_en),   32'(e.clk_en));
            chk("gated",    32'(gated),    32'(e.gated));
            chk("wake_ack", 32'(wake_ack), 32'(e.wake_ack));
            chk("gate_cnt", 32'(gate_cnt), 32'(e.cnt));
        end
    end

    initial begin
        rst_n = 1'b0; busy = 0; wake_req = 0; cfg_gate_dis = 0; cnt_clr = 0; thr = 8'd3;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_clk_en",   32'(clk_en),   32'd1);
        chk("reset_gated",    32'(gated),    32'd0);
        chk("reset_wake_ack", 32'(wake_ack), 32'd0);
        chk("reset_cnt",      32'(gate_cnt), 32'd0);
        rst_n = 1'b1;

        // Idle from reset with threshold 3: gates on the third edge.
        repeat (6) cyc();

        // Held wake request from GATED: clock on, single ack, no gating while held.
        wake_req = 1;
        repeat (10) cyc();
        wake_req = 0;
        repeat (6) cyc();

        // Busy interrupts an idle run at count 2 of 3, then a full run is needed.
        busy = 1; cyc();
        busy = 0; cyc(); cyc();
        busy = 1; cyc();
        busy = 0; repeat (5) cyc();

        // Threshold 0 behaves as 1.
        thr = 8'd0;
        busy = 1; cyc();
        busy = 0; repeat (3) cyc();

        // Gate disable while gated: wake without ack, then stays on.
        cfg_gate_dis = 1; repeat (10) cyc();
        cfg_gate_dis = 0;

        // Reset while gated and while waking.
        thr = 8'd1; repeat (3) cyc();
        do_reset("gated");
        repeat (2) cyc();
        wake_req = 1; cyc(); cyc();
        do_reset("wake");
        repeat (3) cyc();
        wake_req = 0; repeat (3) cyc();

        // Saturate the gate counter, then clear coincident with a gating edge.
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            busy = 0; cyc();
            busy = 1; cyc();
            busy = 0; repeat (3) cyc();
        end
        cfg_gate_dis = 1; repeat (4) cyc();
        cfg_gate_dis = 0; cnt_clr = 1; cyc();
        cnt_clr = 0; repeat (3) cyc();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) thr = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) busy = ~busy;
            if (!wake_req) wake_req = ($urandom_range(0, 29) == 0);
            else if (m_ack_done && $urandom_range(0, 2) == 0) wake_req = 0;
            cfg_gate_dis = ($urandom_range(0, 49) == 0);
            cnt_clr      = ($urandom_range(0, 19) == 0);
            cyc();
            if (i % 500 == 250) begin
                do_reset("rand");
                cyc();
            end
        end

        busy = 0; wake_req = 0; cfg_gate_dis = 0; cnt_clr = 0;
        repeat (3) cyc();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
